// File: rtl/stage_seq_pkg.sv
package stage_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    ERROR     = 3'd6
  } stage_state_e;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;

  function automatic logic [1:0] pc_sel_of(
    input logic jal,
    input logic jalr,
    input logic branch,
    input logic branch_result
  );
    if (jalr)
      return PC_SEL_JALR;
    else if (jal || (branch && branch_result))
      return PC_SEL_TARGET;
    else
      return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
module bus_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count && (cnt_q != 8'(LIMIT)))
      cnt_d = cnt_q + 8'd1;
  end

  // Fires during the LIMIT-th consecutive waiting cycle.
  assign expired = count && !clear && (cnt_q == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer.
// Optional bus timeout / ERROR state: define BUS_TIMEOUT_EN.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic        store,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_result,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic        reg_write_en,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        busy,
  output logic [31:0] retire_count,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  stage_state_e state_q, state_d;
  logic         commit;
  logic         imem_req_q, imem_req_d;
  logic         dmem_req_q, dmem_req_d;
  logic         dmem_we_q, dmem_we_d;
  logic         ir_en_q, ir_en_d;
  logic         pc_en_q, pc_en_d;
  logic         reg_write_en_q, reg_write_en_d;
  logic [1:0]   pc_sel_q, pc_sel_d;
  logic         busy_q, busy_d;
  logic [31:0]  retire_count_q;

`ifdef BUS_TIMEOUT_EN
  logic wait_count;
  logic wait_expired;
  logic bus_err_q, bus_err_d;

  assign wait_count = ((state_q == FETCH) && !imem_ack) ||
                      ((state_q == MEMORY) && !dmem_ack);

  bus_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (!wait_count),
    .count   (wait_count),
    .expired (wait_expired)
  );
`endif

  // Outputs are computed from the transition taken this cycle and registered,
  // so each pulse appears in the cycle after the edge that caused it.
  always_comb begin
    state_d        = state_q;
    commit         = 1'b0;
    reg_write_en_d = 1'b0;
    case (state_q)
      IDLE:      if (run) state_d = FETCH;
      FETCH: begin
        if (imem_ack)
          state_d = DECODE;
`ifdef BUS_TIMEOUT_EN
        else if (wait_expired)
          state_d = ERROR;
`endif
      end
      DECODE:    state_d = EXECUTE;
      EXECUTE: begin
        if (load || store)
          state_d = MEMORY;
        else if (branch)
          commit = 1'b1;
        else
          state_d = WRITEBACK;
      end
      MEMORY: begin
        if (dmem_ack) begin
          if (load)
            state_d = WRITEBACK;
          else
            commit = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wait_expired)
          state_d = ERROR;
`endif
      end
      WRITEBACK: begin
        commit         = 1'b1;
        reg_write_en_d = 1'b1;
      end
`ifdef BUS_TIMEOUT_EN
      ERROR:     state_d = ERROR;
`endif
      default:   state_d = IDLE;
    endcase

    if (commit)
      state_d = run ? FETCH : IDLE;

    ir_en_d    = (state_q == FETCH) && imem_ack;
    imem_req_d = (state_d == FETCH);
    dmem_req_d = (state_d == MEMORY);
    dmem_we_d  = dmem_req_d && store && !load;
    pc_en_d    = commit;
    pc_sel_d   = commit ? pc_sel_of(jal, jalr, branch, branch_result) : PC_SEL_SEQ;
    busy_d     = (state_d != IDLE);
`ifdef BUS_TIMEOUT_EN
    bus_err_d  = bus_err_q || (state_d == ERROR);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      imem_req_q     <= 1'b0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      ir_en_q        <= 1'b0;
      pc_en_q        <= 1'b0;
      reg_write_en_q <= 1'b0;
      pc_sel_q       <= PC_SEL_SEQ;
      busy_q         <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      imem_req_q     <= imem_req_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      ir_en_q        <= ir_en_d;
      pc_en_q        <= pc_en_d;
      reg_write_en_q <= reg_write_en_d;
      pc_sel_q       <= pc_sel_d;
      busy_q         <= busy_d;
      if (commit)
        retire_count_q <= retire_count_q + 32'd1;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus_err_q <= 1'b0;
    else
      bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign imem_req     = imem_req_q;
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign ir_en        = ir_en_q;
  assign pc_en        = pc_en_q;
  assign reg_write_en = reg_write_en_q;
  assign pc_sel       = pc_sel_q;
  assign state        = state_q;
  assign busy         = busy_q;
  assign retire_count = retire_count_q;

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the ack-wait limit in cycles (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port run, input, 1 bit: enables fetching of new instructions.
REQ-005 SHALL have ports load, store, branch, jal, jalr, branch_result, inputs, 1 bit each: decoded class and compare result from the decode stage.
REQ-006 SHALL have ports imem_ack and dmem_ack, inputs, 1 bit each: memory completion strobes.
REQ-007 SHALL have ports imem_req, dmem_req and dmem_we, outputs, 1 bit each: memory requests; dmem_we marks a write.
REQ-008 SHALL have ports ir_en, pc_en and reg_write_en, outputs, 1 bit each: single-cycle enable pulses.
REQ-009 SHALL have port pc_sel, output, 2 bits: 00 = pc+4, 01 = branch/jal target, 10 = jalr target.
REQ-010 SHALL have port state, output, 3 bits (current FSM state), and port busy, output, 1 bit (state != IDLE).
REQ-011 SHALL have port retire_count, output, 32 bits (committed instructions), and port bus_err, output, 1 bit.

Function
REQ-012 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and ERROR; all outputs SHALL be registered.
REQ-013 SHALL move IDLE -> FETCH on the first cycle with run=1.
REQ-014 In FETCH, SHALL hold imem_req=1 until imem_ack; on ack, SHALL pulse ir_en for 1 cycle and move to DECODE.
REQ-015 DECODE SHALL last exactly 1 cycle and then move to EXECUTE.
REQ-016 EXECUTE SHALL last 1 cycle and then move:
- to MEMORY if load or store;
- else to commit if branch;
- else to WRITEBACK.
REQ-017 load and store both asserted SHALL be treated as load; jal and jalr both asserted SHALL be treated as jalr.
REQ-018 In MEMORY, SHALL hold dmem_req=1, with dmem_we=store, until dmem_ack; then a load moves to WRITEBACK and a store commits.
REQ-019 WRITEBACK SHALL pulse reg_write_en for 1 cycle and commit in the same cycle.
REQ-020 A commit SHALL pulse pc_en for 1 cycle with pc_sel set as follows:
- 10 if jalr;
- 01 if jal, or if branch with branch_result=1;
- 00 otherwise.
REQ-021 A commit SHALL increment retire_count by 1, wrapping 0xFFFFFFFF -> 0.
REQ-022 After a commit, SHALL move to FETCH if run=1, else to IDLE.
REQ-023 run falling mid-instruction SHALL NOT abort the instruction; it completes and the FSM goes to IDLE.
REQ-024 An ack arriving while the matching req=0 SHALL be ignored.
REQ-025 Latency from imem_ack to pc_en SHALL be 3 cycles for ALU/jal/jalr, 2 cycles for branch, and 2 cycles + dmem wait + (1 cycle if load) for memory ops.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE and drive every output to 0 (pc_sel=00, retire_count=0, bus_err=0).
REQ-027 Reset mid-request SHALL drop imem_req/dmem_req immediately, with no commit.
REQ-028 After rst deasserts, SHALL stay in IDLE until run=1.

Configuration
REQ-029 Macro BUS_TIMEOUT_EN defined: a wait counter SHALL count cycles spent in FETCH/MEMORY without ack.
- When the count reaches TIMEOUT_CYCLES, the FSM SHALL move to ERROR.
- In ERROR, all requests and enables SHALL be 0 and bus_err=1 (sticky).
- ERROR SHALL be exited only by reset.
REQ-030 Macro BUS_TIMEOUT_EN undefined: there SHALL be no counter and no ERROR state; the FSM waits indefinitely and bus_err is tied 0.

Structure
REQ-031 State encodings (IDLE=0 ... ERROR=6) and pc_sel constants SHALL live in the shared package stage_seq_pkg.
REQ-032 The wait counter SHALL be a sub-module bus_wait_timer (inputs: clear, count; output: expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-033 ADD instruction, run=1, imem_ack on the 2nd FETCH cycle -> ir_en 1 pulse; reg_write_en and pc_en together 3 cycles later; pc_sel=00; retire_count=1.
REQ-034 Branch with branch_result=1 -> pc_en with pc_sel=01, no reg_write_en; branch_result=0 -> pc_sel=00.
REQ-035 Load with dmem_ack after 4 cycles -> dmem_req high for 4 cycles, dmem_we=0, then WRITEBACK; store -> dmem_we=1, commit with no reg_write_en.
REQ-036 jal=jalr=1 -> pc_sel=10; load=store=1 -> dmem_we=0 and reg_write_en pulses.
REQ-037 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold imem_ack -> ERROR after 16 cycles, bus_err=1, imem_req=0; a later imem_ack is ignored.
REQ-038 rst=0 asserted during MEMORY -> dmem_req=0 immediately; with retire_count preloaded to 0xFFFFFFFF, one commit -> 0.
